// File: rtl/seq_player.sv
// Nibble sequence player: shows captured nibbles 0..round,
// each for STEP_TICKS cycles followed by GAP_TICKS blank cycles.
module seq_player #(
  parameter int unsigned STEP_TICKS = 3,
  parameter int unsigned GAP_TICKS  = 2
) (
  input  logic        clk,
  input  logic        R,
  input  logic        start,
  input  logic        abort,
  input  logic [63:0] seq,
  input  logic [3:0]  round,
  output logic [3:0]  nib,
  output logic        nib_valid,
  output logic [3:0]  idx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP,
    DONE
  } state_t;

  localparam logic [23:0] STEP_M1 = 24'(STEP_TICKS - 1);
  localparam logic [23:0] GAP_M1  = 24'(GAP_TICKS - 1);

  state_t      st;
  logic [63:0] cseq;
  logic [3:0]  crnd;
  logic [23:0] cnt;

  // nibble i sits at bit offset 4*(15-i)
  function automatic logic [3:0] pick(
    input logic [63:0] s,
    input logic [3:0]  i
  );
    return s[{~i, 2'b00} +: 4];
  endfunction

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      st        <= IDLE;
      cseq      <= '0;
      crnd      <= '0;
      cnt       <= '0;
      nib       <= '0;
      nib_valid <= 1'b0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            cseq      <= seq;
            crnd      <= round;
            idx       <= '0;
            cnt       <= STEP_M1;
            nib       <= seq[63:60];
            nib_valid <= 1'b1;
            busy      <= 1'b1;
            st        <= SHOW;
          end
        end
        SHOW: begin
          if (abort) begin
            nib       <= '0;
            nib_valid <= 1'b0;
            busy      <= 1'b0;
            st        <= IDLE;
          end else if (cnt == '0) begin
            cnt       <= GAP_M1;
            nib       <= '0;
            nib_valid <= 1'b0;
            st        <= GAP;
          end else begin
            cnt <= cnt - 24'd1;
          end
        end
        GAP: begin
          if (abort) begin
            busy <= 1'b0;
            st   <= IDLE;
          end else if (cnt == '0) begin
            if (idx < crnd) begin
              idx       <= idx + 4'd1;
              nib       <= pick(cseq, idx + 4'd1);
              nib_valid <= 1'b1;
              cnt       <= STEP_M1;
              st        <= SHOW;
            end else begin
              done <= 1'b1;
              st   <= DONE;
            end
          end else begin
            cnt <= cnt - 24'd1;
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_player.md
SEQ_PLAYER -- requirements
Module: seq_player

Interface
REQ-001 Parameter STEP_TICKS, 3, clock cycles each nibble is shown (legal 1..2^24-1).
REQ-002 Parameter GAP_TICKS, 2, clock cycles of blank after each nibble (legal 1..2^24-1).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 R  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request to play the sequence; sampled only in IDLE.
REQ-006 abort  input  1  synchronous cancel of a playback in progress.
REQ-007 seq  input  64  stored game sequence, 16 nibbles, nibble 0 = seq[63:60].
REQ-008 round  input  4  index of last nibble to play (plays round+1 nibbles).
REQ-009 nib  output  4  nibble currently shown; 4'h0 when not showing.
REQ-010 nib_valid  output  1  high while nib carries a sequence nibble.
REQ-011 idx  output  4  index of nibble being shown or just shown.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse on normal completion.

Function
REQ-014 FSM states SHALL be IDLE, SHOW, GAP, DONE; encoding free.
REQ-015 In IDLE with start=1 at an edge, block SHALL capture seq and round into internal registers, set idx=0, load tick counter, enter SHOW.
REQ-016 seq/round changes after capture SHALL have no effect on the running playback.
REQ-017 In SHOW, nib SHALL equal captured nibble idx (bits [63-4*idx : 60-4*idx]) and nib_valid=1, for exactly STEP_TICKS cycles, then enter GAP.
REQ-018 In GAP, nib=4'h0, nib_valid=0 for exactly GAP_TICKS cycles.
REQ-019 GAP end with idx<captured round: idx SHALL increment by 1, enter SHOW.
REQ-020 GAP end with idx==captured round: enter DONE, idx unchanged.
REQ-021 DONE SHALL last exactly one cycle with done=1, then enter IDLE.
REQ-022 start SHALL be ignored in SHOW, GAP and DONE (no restart, no queuing).
REQ-023 abort=1 at an edge in SHOW or GAP SHALL enter IDLE without passing DONE; done stays 0.
REQ-024 abort in IDLE or DONE SHALL have no effect; abort has priority over start only when both high in SHOW/GAP (start ignored there anyway).
REQ-025 Latency: nib_valid SHALL rise in the first cycle after the edge that samples start.
REQ-026 Total playback: (round+1)*(STEP_TICKS+GAP_TICKS) busy cycles before DONE, plus 1 DONE cycle.
REQ-027 round=4'hF SHALL play all 16 nibbles; idx SHALL never wrap past 15.
REQ-028 Tick counter SHALL be 24 bits; no overflow for legal parameters.
REQ-029 Outputs nib, nib_valid, busy, done SHALL be registered or decoded from registered state only (no combinational path from inputs).

Reset
REQ-030 R=0 SHALL immediately force IDLE, nib=4'h0, nib_valid=0, idx=4'h0, busy=0, done=0, captured seq=0, captured round=0, tick counter=0, independent of clk.
REQ-031 R asserted mid-playback SHALL abort without a done pulse; after release, block waits in IDLE for a new start.
REQ-032 First edge after R deasserts SHALL be able to sample start.

Verification
REQ-033 STEP=3, GAP=2, seq=64'h1234_0000_0000_0000, round=3, start pulse -> nib 1,2,3,4 each 3 cycles with nib_valid=1, 2-cycle blanks between, done pulse 1 cycle after 20 busy cycles.
REQ-034 round=4'hF, seq=64'h0123_4567_89AB_CDEF -> nibbles 0..F in order, idx 0..15, done after 80 busy cycles, idx ends 15.
REQ-035 Change seq to 64'hFFFF... and pulse start during playback of scenario 1 -> output sequence unchanged, no restart, single done.
REQ-036 abort at cycle 7 of scenario 1 -> busy=0, nib_valid=0 next cycle, done never asserted; subsequent start plays from idx 0.
REQ-037 R=0 asynchronously mid-SHOW -> all outputs at reset values before next clk edge; playback not resumed after release.
REQ-038 STEP=1, GAP=1, round=0, seq=64'hA000_0000_0000_0000 -> nib=A for 1 cycle, 1 blank cycle, done pulse next cycle.
